// File: rtl/jstk_spi_slave.sv
// PMOD JSTK emulator: SPI mode-0 slave that streams a 5-byte joystick frame on miso
// and captures master command bytes, with all SPI pins oversampled by the system clock.
module jstk_spi_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic [1:0] led_out,
    output logic       frame_done,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

    localparam logic [2:0] ARM_LIM = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [2:0] byte_idx;
    logic [2:0] arm_cnt;
    logic       armed;
    logic [7:0] rx_sh, rx_next;
    logic [7:0] tx_sh, next_tx;
    logic [9:0] snap_x, snap_y;
    logic [2:0] snap_btn;

    // NOTE: every flop here, including the synchronizer chains, is updated with <= so
    // that each stage samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    // The cs chain resets to 'high'; a pin already low at reset would look like a falling
    // edge, so frames are only accepted once cs has really been seen high after reset.
    assign armed   = (arm_cnt == ARM_LIM);
    assign rx_next = {rx_sh[6:0], mosi_s};

    always_comb begin
        next_tx = {8{IDLE_MISO}};
        case (byte_idx)
            3'd0:    next_tx = snap_x[7:0];
            3'd1:    next_tx = {6'b0, snap_x[9:8]};
            3'd2:    next_tx = snap_y[7:0];
            3'd3:    next_tx = {6'b0, snap_y[9:8]};
            3'd4:    next_tx = {5'b0, snap_btn};
            default: next_tx = {8{IDLE_MISO}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            miso       <= IDLE_MISO;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            led_out    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
            arm_cnt    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_btn   <= '0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (!armed)
                arm_cnt <= cs_s ? arm_cnt + 3'd1 : 3'd0;

            if (state != IDLE && cs_rise) begin
                state      <= IDLE;
                busy       <= 1'b0;
                miso       <= IDLE_MISO;
                bit_cnt    <= '0;
                frame_done <= (byte_idx >= 3'd5);
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall && armed) begin
                            snap_x   <= x_pos;
                            snap_y   <= y_pos;
                            snap_btn <= buttons;
                            tx_sh    <= x_pos[7:0];
                            miso     <= x_pos[7];
                            bit_cnt  <= '0;
                            byte_idx <= '0;
                            busy     <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                    SHIFT, OVERRUN: begin
                        if (sclk_rise) begin
                            rx_sh <= rx_next;
                            if (bit_cnt == 3'd7) begin
                                rx_byte  <= rx_next;
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                                if (byte_idx == 3'd0 && rx_next[7])
                                    led_out <= rx_next[1:0];
                                if (byte_idx != 3'd5)
                                    byte_idx <= byte_idx + 3'd1;
                                if (byte_idx == 3'd4) begin
                                    state <= OVERRUN;
                                    miso  <= IDLE_MISO;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (sclk_fall && state == SHIFT) begin
                            // A falling edge with bit_cnt back at 0 opens the next byte.
                            if (bit_cnt == 3'd0) begin
                                tx_sh <= next_tx;
                                miso  <= next_tx[7];
                            end else begin
                                tx_sh <= {tx_sh[6:0], 1'b0};
                                miso  <= tx_sh[6];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
